shift_operand_queue: RTL
========================

Name: shift_operand_queue

Overview:
Upstream feeder stage for the 8-bit combinational barrel shifter.
- Buffers operand pairs (data, shift amount) in a DEPTH-entry FIFO behind a valid/ready handshake.
- Drives the FIFO head onto the shifter inputs and registers the shifter result into a one-entry output stage with its own valid/ready handshake.
- Turns the purely combinational shifter into a flow-controlled, throughput-1 pipeline stage.

Parameters:
DW, 8, data width of operand and result
AW, 3, shift-amount width
DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair offered
in_ready  output  1  queue can accept this cycle
in_data  input  DW  operand to shift
in_amt  input  AW  shift amount
sh_x  output  DW  to shifter data input
sh_amt  output  AW  to shifter amount input
sh_out  input  DW  from shifter result
out_valid  output  1  result held in output register
out_ready  input  1  downstream accepts result
out_data  output  DW  registered shifter result
drop_cnt  output  8  present only with DROP_CNT_EN

Behaviour:
- Reset, asynchronous and active-low: clears wr_ptr, rd_ptr, count, out_valid, out_data and drop_cnt to 0. Storage contents are don't-care. While rst_n is low no push or pop occurs.
- in_ready = (count != DEPTH). It depends only on count, never on out_ready.
- push = in_valid & in_ready. The entry is written at wr_ptr, and wr_ptr wraps modulo DEPTH.
- sh_x / sh_amt = head entry when count != 0, else 0.
- pop = (count != 0) & (!out_valid | out_ready).
  - On pop: out_data <= sh_out, out_valid <= 1, rd_ptr advances with wrap.
  - Else if out_ready: out_valid <= 0.
- count update:
  - push without pop: +1
  - pop without push: -1
  - both: unchanged
- Full: no push even if a pop occurs that cycle; there is no same-cycle pass-through. Empty: no pop. Pointers wrap silently.
- Latency: an entry pushed at edge N (queue empty, output free) is on sh_x/sh_amt during cycle N+1. out_valid rises after edge N+1.
- Throughput is one result per cycle with out_ready held high.
- Holding: while out_valid=1 and out_ready=0, out_data is stable and the FIFO is frozen. Total capacity is DEPTH+1 entries including the output register.
- Reset mid-operation discards all queued and held entries. out_valid is 0 immediately and no partial result is ever emitted.
- The block never inspects sh_out beyond registering it. The shift semantics are owned by the shifter.

Optional Feature:
Macro DROP_CNT_EN.
- With the macro: port drop_cnt is present. It is an 8-bit counter incremented each cycle in_valid=1 & in_ready=0, saturates at 255, and is cleared only by reset.
- Without the macro: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package bs_pkg: DW and AW constants, DEPTH default, and the entry type bs_entry_t = {data[DW-1:0], amt[AW-1:0]}.
- One sub-module, bs_sync_fifo: storage, pointers, count, full/empty flags.
- The top level adds the output register, the pop logic and the drop counter.

Test Plan:
All cases use a bench stub shifter with sh_out = sh_x << sh_amt, truncated to 8 bits.
1. rst_n low 3 cycles with in_valid=1, in_data=8'hFF -> out_valid=0, out_data=0. After release in_ready=1, and nothing is queued from the reset window.
2. Push in_data=8'hA5, in_amt=3 with out_ready=1 -> next cycle sh_x=8'hA5, sh_amt=3. The cycle after, out_valid=1 and out_data=8'h28 for exactly one cycle.
3. Push 8 back-to-back entries (8'h01, amt 0..7) with out_ready=1:
   - in_ready stays 1 throughout.
   - out_data sequence is 01,02,04,08,10,20,40,80 on 8 consecutive cycles, in order.
4. out_ready=0, offer 7 entries continuously -> 5 accepted (1 in the output register, 4 in the FIFO), then in_ready=0. With DROP_CNT_EN, drop_cnt counts every stalled cycle and saturates at 255 on a long stall.
5. With out_valid=1 and out_ready=0 held for 5 cycles -> out_data constant. Raising out_ready then drains the entries in FIFO order, one per cycle.
6. Assert rst_n low for 1 cycle with 3 entries queued -> out_valid=0 and in_ready=1 after release. Only new pushes appear at the output afterwards.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared constants and operand-entry type for the barrel-shifter feeder stage.
package bs_pkg;

    localparam int BS_DW    = 8;
    localparam int BS_AW    = 3;
    localparam int BS_DEPTH = 4;

    typedef struct packed {
        logic [BS_DW-1:0] data;
        logic [BS_AW-1:0] amt;
    } bs_entry_t;

endpackage

// File: rtl/bs_sync_fifo.sv
// Synchronous FIFO for operand entries; pointers wrap naturally since DEPTH is a power of two.
module bs_sync_fifo
    import bs_pkg::*;
#(
    parameter int W     = $bits(bs_entry_t),
    parameter int DEPTH = BS_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Storage is left unreset; only the bookkeeping state defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/shift_operand_queue.sv
// Flow-controlled feeder for the combinational barrel shifter: FIFO + registered result stage.
// Optional drop counter port enabled by defining DROP_CNT_EN.
module shift_operand_queue
    import bs_pkg::*;
#(
    parameter int DW    = BS_DW,
    parameter int AW    = BS_AW,
    parameter int DEPTH = BS_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [AW-1:0] in_amt,
    output logic [DW-1:0] sh_x,
    output logic [AW-1:0] sh_amt,
    input  logic [DW-1:0] sh_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
`ifdef DROP_CNT_EN
    ,
    output logic [7:0]    drop_cnt
`endif
);

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [DW+AW-1:0] head;

    bs_sync_fifo #(
        .W     (DW + AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data ({in_data, in_amt}),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // A full queue refuses input even when a pop frees a slot this cycle.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = !empty && (!out_valid || out_ready);

    assign sh_x   = empty ? '0 : head[AW +: DW];
    assign sh_amt = empty ? '0 : head[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= sh_out;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DROP_CNT_EN
    // Counts refused offers, saturating so a long stall never wraps to a small value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (in_valid && !in_ready && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule
